// File: rtl/cache_port_scheduler.sv
// cache_port_scheduler: grants the external memory port to the I-cache or D-cache for whole transactions
module cache_port_scheduler #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_done,
  output logic i_gnt,
  input  logic d_req,
  input  logic d_done,
  output logic d_gnt,
  output logic sel,
  output logic busy,
  output logic timeout_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wd_cnt;
  logic done, wd_exp, starved;
  always_comb begin
    done = (state == GRANT_I) ? i_done : (state == GRANT_D) ? d_done : 1'b0;
    wd_exp = (state != IDLE) && (wd_cnt == WW'(TIMEOUT - 1)) && !done;
    starved = starve_cnt >= SW'(STARVE_LIMIT);
    state_nxt = (state != IDLE) ? ((done || wd_exp) ? IDLE : state) :
                (d_req && !(i_req && starved)) ? GRANT_D :
                i_req ? GRANT_I : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      wd_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      timeout_err <= wd_exp;
      wd_cnt <= (state == IDLE) ? '0 : wd_cnt + 1'b1;
      starve_cnt <= (state == IDLE && state_nxt == GRANT_I) ? '0 :
                    (i_req && state != GRANT_I && !starved) ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
  assign i_gnt = state == GRANT_I;
  assign d_gnt = state == GRANT_D;
  assign sel = d_gnt;
  assign busy = i_gnt | d_gnt;
endmodule

// File: tb/tb_cache_port_scheduler.sv
// tb_cache_port_scheduler: directed vectors plus multi-cycle sequences and a protocol soak
module tb_cache_port_scheduler;
  localparam int SL = 8;
  localparam int TO = 16;
  localparam logic [4:0] O_IDLE = 5'b00000, O_I = 5'b10010, O_D = 5'b01110, O_TO = 5'b00001;
  logic clk = 0, rst = 1, i_req = 0, i_done = 0, d_req = 0, d_done = 0;
  logic i_gnt, d_gnt, sel, busy, timeout_err;
  logic [4:0] outs;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic r, ir, id, dr, dd;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[13];
  cache_port_scheduler #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_done(i_done), .i_gnt(i_gnt),
    .d_req(d_req), .d_done(d_done), .d_gnt(d_gnt), .sel(sel), .busy(busy),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  assign outs = {i_gnt, d_gnt, sel, busy, timeout_err};
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic ir, input logic id, input logic dr, input logic dd);
    rst = r; i_req = ir; i_done = id; d_req = dr; d_done = dd;
    @(posedge clk);
    #1;
  endtask
  int i_wait;
  logic prev_i, prev_d;
  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, O_IDLE};
    vecs[1]  = '{0, 1, 0, 0, 0, O_I};
    vecs[2]  = '{0, 0, 0, 0, 0, O_I};
    vecs[3]  = '{0, 0, 0, 0, 1, O_I};
    vecs[4]  = '{0, 0, 1, 0, 0, O_IDLE};
    vecs[5]  = '{0, 0, 0, 1, 0, O_D};
    vecs[6]  = '{0, 0, 1, 0, 0, O_D};
    vecs[7]  = '{0, 1, 1, 0, 1, O_IDLE};
    vecs[8]  = '{0, 1, 0, 1, 0, O_D};
    vecs[9]  = '{0, 0, 0, 0, 1, O_IDLE};
    vecs[10] = '{0, 0, 0, 0, 1, O_IDLE};
    vecs[11] = '{0, 1, 1, 0, 0, O_I};
    vecs[12] = '{0, 0, 1, 0, 0, O_IDLE};
    for (int k = 0; k < 13; k++) begin
      cyc(vecs[k].r, vecs[k].ir, vecs[k].id, vecs[k].dr, vecs[k].dd);
      chk($sformatf("vec%0d", k), 32'(outs), 32'(vecs[k].exp));
    end
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 3; c++) begin
        cyc(0, 1, 0, 1, 0);
        chk($sformatf("prio_d%0d_c%0d", g, c), 32'(outs), 32'(O_D));
      end
      cyc(0, 1, 0, 1, 1);
      chk($sformatf("prio_rel%0d", g), 32'(outs), 32'(O_IDLE));
    end
    cyc(0, 1, 0, 1, 0);
    chk("starve_win", 32'(outs), 32'(O_I));
    chk("starve_clr", 32'(dut.starve_cnt), 0);
    cyc(0, 0, 1, 1, 0);
    chk("starve_rel", 32'(outs), 32'(O_IDLE));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("wd_grant", 32'(outs), 32'(O_D));
    for (int c = 2; c <= TO; c++) begin
      cyc(0, 0, 0, 0, 0);
      if (c == TO) chk("wd_hold_last", 32'(outs), 32'(O_D));
    end
    cyc(0, 0, 0, 0, 0);
    chk("wd_abort", 32'(outs), 32'(O_TO));
    cyc(0, 0, 0, 0, 0);
    chk("wd_pulse_end", 32'(outs), 32'(O_IDLE));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int c = 2; c <= TO; c++) cyc(0, 0, 0, 0, 0);
    chk("wd2_hold", 32'(outs), 32'(O_D));
    cyc(0, 0, 0, 0, 1);
    chk("wd2_done_wins", 32'(outs), 32'(O_IDLE));
    cyc(0, 0, 0, 0, 0);
    chk("wd2_no_err", 32'(outs), 32'(O_IDLE));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("rst_pre", 32'(outs), 32'(O_I));
    cyc(1, 1, 0, 1, 0);
    chk("rst_outs", 32'(outs), 32'(O_IDLE));
    chk("rst_cnts", 32'({dut.starve_cnt, dut.wd_cnt}), 0);
    cyc(0, 1, 0, 1, 0);
    chk("rst_regrant", 32'(outs), 32'(O_D));
    cyc(1, 0, 0, 0, 0);
    i_wait = 0;
    prev_i = 0;
    prev_d = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc(0, i_gnt ? 1'b0 : (i_req | ($urandom_range(3) == 0)),
          i_gnt ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0),
          d_gnt ? 1'b0 : (d_req | ($urandom_range(2) == 0)),
          d_gnt ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0));
      chk("soak_excl", 32'(i_gnt & d_gnt), 0);
      chk("soak_bubble", 32'((prev_i & d_gnt) | (prev_d & i_gnt)), 0);
      chk("soak_decode", 32'({busy, sel}), 32'({i_gnt | d_gnt, d_gnt}));
      if (i_gnt && !prev_i) begin
        chk("soak_starve", 32'(i_wait <= SL + 2 * TO + 4), 1);
        i_wait = 0;
      end else if (i_req && !i_gnt) i_wait++;
      prev_i = i_gnt;
      prev_d = d_gnt;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
